literal_assign: RTL and testbench
=================================

# literal_assign

Applies one decided literal (pure or unit) to a formula and emits the simplified formula. It sits directly downstream of `Pure_literal`: `lit_found` feeds `assign_lit` and the formula under search feeds `in_formula`. The block scans one clause per cycle:

- clauses containing the literal are dropped;
- the complementary literal is deleted from the remaining clauses;
- surviving clauses are compacted in order.

## Interface

Parameters: none. Sizes come from package `common`.

Ports (clock and reset first):
- `clock`  in  1  single clock domain; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `in_formula`  in  formula  formula to simplify; captured on an accepted `start`.
- `assign_lit`  in  lit  literal being set true; captured on an accepted `start`.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `out_formula`  out  formula  simplified formula; held until the next accepted `start`.
- `conflict`  out  1  some clause became empty; held with `out_formula`.
- `sat`  out  1  result count is 0 and `conflict` is 0; held with `out_formula`.

## Operation

State machine:
- IDLE:
  - On `start`, latch `in_formula` and `assign_lit`.
  - Clear the output formula to zero clauses, count 0.
  - Clear `conflict` and `sat`; set rd=0, wr=0.
  - Go to SCAN.
- SCAN: each cycle, process clause rd (see per-clause rules).
  - If rd is the last clause (rd = N−1, where N = latched clause count) → DONE.
  - If N = 0 → DONE on the first SCAN cycle.
- DONE:
  - Pulse `done` and compute `sat`.
  - Return to IDLE next cycle.

Per-clause rules, for clause with lit count k:
- Only the first k literals are examined; slots ≥ k are ignored.
- Satisfied: some literal has the same var and same polarity as `assign_lit`. The clause is dropped; wr is unchanged.
- Otherwise:
  - Remove every literal with the same var and opposite polarity.
  - Left-pack the survivors in original order and fill the tail with `zero_lit`.
  - Count = k − removed.
  - Write to out slot wr; wr+1; output formula count = wr+1.
- Reduced count 0 from k > 0 → set `conflict` (sticky for this operation). The empty clause is still written, and scanning continues.
- Clause slots ≥ N in `out_formula` are all `zero_lit` with count 0.

Other behaviours:
- `assign_lit` with var 0 matches nothing; the output equals the input with untouched slots zeroed.
- `start` while `busy` is ignored. Inputs may change freely after capture.
- Widths: var 3 bits, clause count 3 bits (max 5), formula count 4 bits (max 10). Counts never exceed their input values, so no wrap is possible.

## Timing

- Reset values (reset=0): state IDLE; `busy`, `done`, `conflict`, `sat` = 0; `out_formula` all `zero_lit`, all counts 0.
- Reset mid-SCAN: abort with no `done`; the partial result is discarded.
- `start` sampled at edge E0 → SCAN.
- Clause i is processed at edge E(i+1).
- DONE is entered at edge E(max(N,1)); `done`=1 for exactly the cycle after it.
- Latency from `start` to `done` is max(N,1)+1 cycles; a new `start` is accepted the cycle after `done`.
- `out_formula` may show a partial result during SCAN. Consumers read it only at or after `done`.

## Structure

- Package `common` holds the existing `lit`, `clause`, `formula`, and `zero_lit`.
- Add to `common`: `MAX_LITS`=5, `MAX_CLAUSES`=10, and the state enum `la_state_t` {IDLE, SCAN, DONE}.
- Sub-module `clause_reduce` (combinational) takes (clause, lit) and returns (reduced clause, satisfied, emptied). It does the compaction; `literal_assign` keeps the FSM, pointers and registers.

## Test plan

Base formula F, 10 clauses in order: {1+,2+,3+,4+,5+}, {2−,5−}, {1−,2−,5−}, {1+,2+}, {1+}, {2+}, {3+}, {4+}, {2−,3−,4+}, {3−,2+}.

1. F, `assign_lit`={4,+} → count 7 (clauses 0, 7, 8 dropped, order kept); `conflict`=0; `sat`=0; `done` at cycle 11.
2. F, {1,−} → clause 0 becomes {2+,3+,4+,5+} with count 4; clause 2 dropped; {1+,2+} becomes {2+}; {1+} becomes empty, so `conflict`=1; output count 9.
3. Single clause {2+,5−,3+}, {5,+} → {2+,3+,zero,zero,zero} with count 2.
4. Formula count 0 → `done` 2 cycles after `start`; `sat`=1; `out_formula` all zero.
5. {1+}, {1+,2−} with {1,+} → count 0; `sat`=1; `conflict`=0.
6. Start on F, then:
   - a second `start` at cycle 3 is ignored;
   - asserting `reset`=0 at cycle 5 zeros all outputs asynchronously, with no `done`;
   - after release, a new `start` completes normally.

Source files
------------

// File: rtl/common_pkg.sv
// Shared SAT-solver types and constants.
//   lit      : one literal, a 3-bit variable id plus a polarity bit (1 = positive)
//   clause   : up to MAX_LITS literals plus a 3-bit literal count
//   formula  : up to MAX_CLAUSES clauses plus a 4-bit clause count
//   zero_lit : the empty literal (variable 0) used to pad unused slots
//   la_state_t : control states of literal_assign
package common;

    localparam int MAX_LITS    = 5;
    localparam int MAX_CLAUSES = 10;
    localparam int VAR_W       = 3;
    localparam int CCNT_W      = 3;
    localparam int FCNT_W      = 4;

    typedef struct packed {
        logic [VAR_W-1:0] var_id;
        logic             pos;
    } lit;

    typedef struct packed {
        lit [MAX_LITS-1:0] lits;
        logic [CCNT_W-1:0] cnt;
    } clause;

    typedef struct packed {
        clause [MAX_CLAUSES-1:0] clauses;
        logic [FCNT_W-1:0]       cnt;
    } formula;

    localparam lit zero_lit = '{var_id: 3'd0, pos: 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } la_state_t;

    // A literal satisfies its clause when it equals the assigned literal.
    // Variable 0 is reserved as "no literal" and never matches.
    function automatic logic lit_sat(input lit l, input lit a);
        return (a.var_id != 3'd0) && (l.var_id == a.var_id) && (l.pos == a.pos);
    endfunction

    // A literal is falsified (and removed) when it is the complement.
    function automatic logic lit_kill(input lit l, input lit a);
        return (a.var_id != 3'd0) && (l.var_id == a.var_id) && (l.pos != a.pos);
    endfunction

endpackage

// File: rtl/literal_assign_clause_reduce.sv
// clause_reduce: combinational simplification of one clause under one
// assigned literal.
//   i_clause : clause to reduce (only the first cnt literals are examined)
//   i_lit    : literal being set true
//   o_clause : surviving literals left-packed in order, tail = zero_lit
//   o_sat    : clause contains i_lit and is to be dropped
//   o_empty  : clause was non-empty, is not satisfied, and lost every literal
module clause_reduce
    import common::*;
(
    input  clause i_clause,
    input  lit    i_lit,
    output clause o_clause,
    output logic  o_sat,
    output logic  o_empty
);

    logic [CCNT_W-1:0] w_wp;

    // Scan the live slots, flag satisfaction and compact the survivors.
    always_comb begin
        o_clause = '0;
        o_sat    = 1'b0;
        w_wp     = 3'd0;
        for (int j = 0; j < MAX_LITS; j++) begin
            o_clause.lits[j] = zero_lit;
        end
        for (int j = 0; j < MAX_LITS; j++) begin
            if (3'(j) < i_clause.cnt) begin
                o_sat = o_sat | lit_sat(i_clause.lits[j], i_lit);
                if (lit_kill(i_clause.lits[j], i_lit)) begin
                    w_wp = w_wp;
                end else begin
                    // w_wp never exceeds j here, so the write stays in range
                    o_clause.lits[w_wp] = i_clause.lits[j];
                    w_wp = w_wp + 3'd1;
                end
            end else begin
                o_sat = o_sat;
            end
        end
        o_clause.cnt = w_wp;
        o_empty      = !o_sat && (i_clause.cnt != 3'd0) && (w_wp == 3'd0);
    end

endmodule

// File: rtl/literal_assign.sv
// literal_assign: applies one decided literal to a formula, one clause per
// cycle. Satisfied clauses are dropped, complementary literals are removed,
// and surviving clauses are compacted in their original order.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   start       : request, sampled only when idle
//   in_formula  : formula captured on an accepted start
//   assign_lit  : literal set true, captured on an accepted start
//   busy        : high while scanning and in the done cycle
//   done        : one-cycle pulse, results valid from this cycle
//   out_formula : simplified formula, held until the next accepted start
//   conflict    : some clause became empty
//   sat         : no clauses remain and no conflict occurred
module literal_assign
    import common::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   start,
    input  formula in_formula,
    input  lit     assign_lit,
    output logic   busy,
    output logic   done,
    output formula out_formula,
    output logic   conflict,
    output logic   sat
);

    la_state_t         r_state;
    la_state_t         w_state_nx;
    formula            r_in;
    lit                r_lit;
    logic [FCNT_W-1:0] r_rd;
    logic [FCNT_W-1:0] r_wr;
    formula            r_out;
    logic              r_conflict;
    logic              r_sat;

    clause             w_cur;
    clause             w_red;
    logic              w_csat;
    logic              w_cempty;
    logic              w_empty_f;
    logic              w_last;
    logic              w_take;
    logic [FCNT_W-1:0] w_wr_nx;
    logic              w_conf_nx;

    // r_rd only advances while it is below the last clause, so it stays in 0..9.
    assign w_cur = r_in.clauses[r_rd];

    clause_reduce u_reduce (
        .i_clause (w_cur),
        .i_lit    (r_lit),
        .o_clause (w_red),
        .o_sat    (w_csat),
        .o_empty  (w_cempty)
    );

    // An empty formula still spends one SCAN cycle, then finishes.
    assign w_empty_f = (r_in.cnt == 4'd0);
    assign w_last    = w_empty_f || (r_rd == (r_in.cnt - 4'd1));
    assign w_take    = (r_state == SCAN) && !w_empty_f && !w_csat;
    assign w_wr_nx   = w_take ? (r_wr + 4'd1) : r_wr;
    assign w_conf_nx = r_conflict | (w_take & w_cempty);

    // Control state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = SCAN;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = SCAN;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Operand capture, clause pointers and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in       <= '0;
            r_lit      <= zero_lit;
            r_rd       <= 4'd0;
            r_wr       <= 4'd0;
            r_out      <= '0;
            r_conflict <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_in       <= in_formula;
                        r_lit      <= assign_lit;
                        r_rd       <= 4'd0;
                        r_wr       <= 4'd0;
                        r_out      <= '0;
                        r_conflict <= 1'b0;
                        r_sat      <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_take) begin
                        r_out.clauses[r_wr] <= w_red;
                        r_out.cnt           <= w_wr_nx;
                    end
                    r_wr       <= w_wr_nx;
                    r_conflict <= w_conf_nx;
                    if (w_last) begin
                        // sat is settled on entry to DONE so it is valid with done
                        r_sat <= (w_wr_nx == 4'd0) && !w_conf_nx;
                    end else begin
                        r_rd <= r_rd + 4'd1;
                    end
                end
                DONE: begin
                    r_sat <= r_sat;
                end
                default: begin
                    r_sat <= r_sat;
                end
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign out_formula = r_out;
    assign conflict    = r_conflict;
    assign sat         = r_sat;

endmodule

// File: tb/tb_literal_assign.sv
module tb_literal_assign;
    import common::*;

    logic   clock = 1'b0;
    logic   reset;
    logic   start;
    formula in_formula;
    lit     assign_lit;
    logic   busy;
    logic   done;
    formula out_formula;
    logic   conflict;
    logic   sat;

    int n_chk  = 0;
    int n_fail = 0;

    literal_assign dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .in_formula  (in_formula),
        .assign_lit  (assign_lit),
        .busy        (busy),
        .done        (done),
        .out_formula (out_formula),
        .conflict    (conflict),
        .sat         (sat)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Literal from a signed int: +v positive, -v negative, 0 empty.
    function automatic lit mkl(input int x);
        lit l;
        l.var_id = 3'((x < 0) ? -x : x);
        l.pos    = (x > 0);
        return l;
    endfunction

    function automatic clause mkc(input int n, input int a, input int b,
                                  input int c, input int d, input int e);
        clause cl;
        cl         = '0;
        cl.cnt     = 3'(n);
        cl.lits[0] = mkl(a);
        cl.lits[1] = mkl(b);
        cl.lits[2] = mkl(c);
        cl.lits[3] = mkl(d);
        cl.lits[4] = mkl(e);
        return cl;
    endfunction

    function automatic formula mk_f();
        formula f;
        f            = '0;
        f.cnt        = 4'd10;
        f.clauses[0] = mkc(5,  1,  2,  3, 4, 5);
        f.clauses[1] = mkc(2, -2, -5,  0, 0, 0);
        f.clauses[2] = mkc(3, -1, -2, -5, 0, 0);
        f.clauses[3] = mkc(2,  1,  2,  0, 0, 0);
        f.clauses[4] = mkc(1,  1,  0,  0, 0, 0);
        f.clauses[5] = mkc(1,  2,  0,  0, 0, 0);
        f.clauses[6] = mkc(1,  3,  0,  0, 0, 0);
        f.clauses[7] = mkc(1,  4,  0,  0, 0, 0);
        f.clauses[8] = mkc(3, -2, -3,  4, 0, 0);
        f.clauses[9] = mkc(2, -3,  2,  0, 0, 0);
        return f;
    endfunction

    // Random formula; slots past each count hold junk that must be ignored.
    function automatic formula rnd_f();
        formula f;
        f.cnt = 4'($urandom_range(0, 10));
        for (int i = 0; i < MAX_CLAUSES; i++) begin
            f.clauses[i].cnt = 3'($urandom_range(0, 5));
            for (int j = 0; j < MAX_LITS; j++) begin
                f.clauses[i].lits[j].var_id = 3'($urandom_range(0, 4));
                f.clauses[i].lits[j].pos    = 1'($urandom);
            end
        end
        return f;
    endfunction

    function automatic lit rnd_l();
        lit l;
        l.var_id = 3'($urandom_range(0, 4));
        l.pos    = 1'($urandom);
        return l;
    endfunction

    // Reference: treat each clause as a list, filter it, and keep the
    // survivors in a growing output list.
    function automatic void model(input formula f, input lit a, output formula e,
                                  output logic c, output logic s);
        lit q[$];
        int w;
        int k;
        bit hit;
        e = '0;
        c = 1'b0;
        w = 0;
        for (int i = 0; i < int'(f.cnt); i++) begin
            q.delete();
            hit = 1'b0;
            k   = int'(f.clauses[i].cnt);
            for (int j = 0; j < k; j++) begin
                if (a.var_id != 3'd0 && f.clauses[i].lits[j].var_id == a.var_id) begin
                    if (f.clauses[i].lits[j].pos == a.pos) hit = 1'b1;
                end else begin
                    q.push_back(f.clauses[i].lits[j]);
                end
            end
            if (!hit) begin
                e.clauses[w].cnt = 3'(q.size());
                for (int j = 0; j < q.size(); j++) e.clauses[w].lits[j] = q[j];
                if (k > 0 && q.size() == 0) c = 1'b1;
                w++;
            end
        end
        e.cnt = 4'(w);
        s     = (w == 0) && !c;
    endfunction

    // One full operation: start, wait (bounded) for done, compare to model,
    // then check the pulse ended and results are held.
    task automatic do_op(input string tag, input formula f, input lit a, input bit poke);
        formula ef;
        logic   ec;
        logic   es;
        int     lat;
        int     nn;
        model(f, a, ef, ec, es);
        nn = (f.cnt == 4'd0) ? 1 : int'(f.cnt);
        @(negedge clock);
        in_formula = f;
        assign_lit = a;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        in_formula = rnd_f();
        assign_lit = rnd_l();
        lat = 1;
        while (!done && lat < 40) begin
            start      = poke ? 1'($urandom) : 1'b0;
            in_formula = rnd_f();
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"},  256'(lat),         256'(nn + 1));
        chk({tag, "_form"}, 256'(out_formula), 256'(ef));
        chk({tag, "_conf"}, 256'(conflict),    256'(ec));
        chk({tag, "_sat"},  256'(sat),         256'(es));
        chk({tag, "_busy"}, 256'(busy),        256'(1'b1));
        @(negedge clock);
        chk({tag, "_done_end"}, 256'(done),        256'(1'b0));
        chk({tag, "_idle"},     256'(busy),        256'(1'b0));
        chk({tag, "_hold"},     256'(out_formula), 256'(ef));
    endtask

    initial begin
        formula f;
        reset      = 1'b0;
        start      = 1'b0;
        in_formula = '0;
        assign_lit = zero_lit;
        repeat (2) @(negedge clock);
        chk("rst_busy", 256'(busy),        256'(1'b0));
        chk("rst_done", 256'(done),        256'(1'b0));
        chk("rst_form", 256'(out_formula), 256'(0));
        chk("rst_conf", 256'(conflict),    256'(1'b0));
        chk("rst_sat",  256'(sat),         256'(1'b0));
        reset = 1'b1;

        // 1: assign 4+
        do_op("t1", mk_f(), mkl(4), 1'b0);
        chk("t1_cnt",  256'(out_formula.cnt), 256'(4'd7));
        chk("t1_c0",   256'(out_formula.clauses[0]), 256'(mkc(2, -2, -5, 0, 0, 0)));
        chk("t1_conf", 256'(conflict), 256'(1'b0));
        chk("t1_sat0", 256'(sat),      256'(1'b0));

        // 2: assign 1-
        do_op("t2", mk_f(), mkl(-1), 1'b0);
        chk("t2_cnt",  256'(out_formula.cnt), 256'(4'd9));
        chk("t2_c0",   256'(out_formula.clauses[0]), 256'(mkc(4, 2, 3, 4, 5, 0)));
        chk("t2_c2",   256'(out_formula.clauses[2]), 256'(mkc(1, 2, 0, 0, 0, 0)));
        chk("t2_conf", 256'(conflict), 256'(1'b1));

        // 3: single clause, complement in the middle
        f            = '0;
        f.cnt        = 4'd1;
        f.clauses[0] = mkc(3, 2, -5, 3, 0, 0);
        do_op("t3", f, mkl(5), 1'b0);
        chk("t3_c0", 256'(out_formula.clauses[0]), 256'(mkc(2, 2, 3, 0, 0, 0)));

        // 4: empty formula with junk in the unused slots
        f     = rnd_f();
        f.cnt = 4'd0;
        do_op("t4", f, mkl(3), 1'b0);
        chk("t4_sat",  256'(sat),         256'(1'b1));
        chk("t4_form", 256'(out_formula), 256'(0));

        // 5: every clause satisfied
        f            = '0;
        f.cnt        = 4'd2;
        f.clauses[0] = mkc(1, 1, 0, 0, 0, 0);
        f.clauses[1] = mkc(2, 1, -2, 0, 0, 0);
        do_op("t5", f, mkl(1), 1'b0);
        chk("t5_cnt",  256'(out_formula.cnt), 256'(4'd0));
        chk("t5_sat",  256'(sat),      256'(1'b1));
        chk("t5_conf", 256'(conflict), 256'(1'b0));

        // 6: ignored restart, then asynchronous reset mid-scan
        @(negedge clock);
        in_formula = mk_f();
        assign_lit = mkl(4);
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        in_formula = rnd_f();
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t6_busy_mid", 256'(busy), 256'(1'b1));
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", 256'(busy),        256'(1'b0));
        chk("t6_rst_form", 256'(out_formula), 256'(0));
        chk("t6_rst_conf", 256'(conflict),    256'(1'b0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("t6_no_done", 256'(done | busy), 256'(1'b0));
        end
        do_op("t6_after", mk_f(), mkl(4), 1'b0);

        // Randomized operations with start poked while busy.
        for (int n = 0; n < 30; n++) begin
            do_op("rnd", rnd_f(), rnd_l(), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
